// File: rtl/axi_slave_mem.sv
// AXI word-memory slave with independent single-outstanding write and read FSMs.
// Optional address range checking (DECERR responses) is built when AXI_SLAVE_DECERR_EN is defined.
module axi_slave_mem #(
    parameter int BUS_WIDTH  = 32,
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  clr,
    // write address channel
    input  logic [ID_WIDTH-1:0]   AWID,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic [3:0]            AWLEN,
    input  logic [2:0]            AWSIZE,
    input  logic [1:0]            AWBURST,
    input  logic [1:0]            AWLOCK,
    input  logic [3:0]            AWCACHE,
    input  logic [2:0]            AWPROT,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    // write data channel
    input  logic [ID_WIDTH-1:0]   WID,
    input  logic [BUS_WIDTH-1:0]  WDATA,
    input  logic [3:0]            WSTRB,
    input  logic                  WLAST,
    input  logic                  WVALID,
    output logic                  WREADY,
    // write response channel
    output logic [ID_WIDTH-1:0]   BID,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    // read address channel
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [3:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic [1:0]            ARLOCK,
    input  logic [3:0]            ARCACHE,
    input  logic [2:0]            ARPROT,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    // read data channel
    output logic [ID_WIDTH-1:0]   RID,
    output logic [BUS_WIDTH-1:0]  RDATA,
    output logic [3:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int LANES = 4;
`ifdef AXI_SLAVE_DECERR_EN
    // Full word address is tracked so out-of-range beats can be detected.
    localparam int WA_W = ADDR_WIDTH - 2;
`else
    localparam int WA_W = IDX_W;
`endif

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    logic run_reg;

    // write side state
    logic [1:0]          w_state_reg;
    logic [1:0]          w_state_next;
    logic [ID_WIDTH-1:0] w_id_reg;
    logic [WA_W-1:0]     w_addr_reg;
    logic                w_err_reg;
    logic                aw_hs;
    logic                w_hs;
    logic                w_beat_ok;
    logic                w_en;
    logic [IDX_W-1:0]    w_idx;

    // read side state
    logic [0:0]          r_state_reg;
    logic [0:0]          r_state_next;
    logic [ID_WIDTH-1:0] r_id_reg;
    logic [WA_W-1:0]     r_addr_reg;
    logic [3:0]          r_len_reg;
    logic [3:0]          r_cnt_reg;
    logic                r_err_reg;
    logic                ar_hs;
    logic                r_hs;
    logic                r_last;
    logic [WA_W-1:0]     r_fetch_addr;
    logic [IDX_W-1:0]    r_fetch_idx;
    logic                r_fetch_en;
    logic                r_fetch_oor;
    logic [BUS_WIDTH-1:0] rd_word;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            run_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
        end
    end

    // ---------------- write path ----------------
    assign aw_hs = AWREADY && AWVALID;
    assign w_hs  = WREADY && WVALID;
    assign w_idx = w_addr_reg[IDX_W-1:0];

`ifdef AXI_SLAVE_DECERR_EN
    assign w_beat_ok = (w_addr_reg[WA_W-1:IDX_W] == '0);
`else
    assign w_beat_ok = 1'b1;
`endif
    assign w_en = w_hs && w_beat_ok;

    always_comb begin
        w_state_next = w_state_reg;
        case (w_state_reg)
            W_IDLE:  if (aw_hs) w_state_next = W_DATA;
            W_DATA:  if (w_hs && WLAST) w_state_next = W_RESP;
            W_RESP:  if (BREADY) w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            w_state_reg <= W_IDLE;
            w_id_reg    <= '0;
            w_addr_reg  <= '0;
            w_err_reg   <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            if (aw_hs) begin
                w_id_reg   <= AWID;
                w_addr_reg <= AWADDR[2 +: WA_W];
                w_err_reg  <= 1'b0;
            end else if (w_hs) begin
                w_addr_reg <= w_addr_reg + WA_W'(1);
                if (!w_beat_ok) begin
                    w_err_reg <= 1'b1;
                end
            end
        end
    end

    assign AWREADY = run_reg && (w_state_reg == W_IDLE);
    assign WREADY  = (w_state_reg == W_DATA);
    assign BVALID  = (w_state_reg == W_RESP);
    assign BID     = w_id_reg;
    assign BRESP   = {w_err_reg, w_err_reg};

    // ---------------- read path ----------------
    assign ar_hs  = ARREADY && ARVALID;
    assign r_hs   = RVALID && RREADY;
    assign r_last = RVALID && (r_cnt_reg == r_len_reg);

    // The next beat is prefetched on the handshake edge so beats run back-to-back.
    assign r_fetch_addr = ar_hs ? ARADDR[2 +: WA_W] : (r_addr_reg + WA_W'(1));
    assign r_fetch_idx  = r_fetch_addr[IDX_W-1:0];
    assign r_fetch_en   = ar_hs || (r_hs && !r_last);

`ifdef AXI_SLAVE_DECERR_EN
    assign r_fetch_oor = (r_fetch_addr[WA_W-1:IDX_W] != '0);
`else
    assign r_fetch_oor = 1'b0;
`endif

    always_comb begin
        r_state_next = r_state_reg;
        case (r_state_reg)
            R_IDLE:  if (ar_hs) r_state_next = R_DATA;
            R_DATA:  if (r_hs && r_last) r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state_reg <= R_IDLE;
            r_id_reg    <= '0;
            r_addr_reg  <= '0;
            r_len_reg   <= '0;
            r_cnt_reg   <= '0;
            r_err_reg   <= 1'b0;
        end else begin
            r_state_reg <= r_state_next;
            if (ar_hs) begin
                r_id_reg  <= ARID;
                r_len_reg <= ARLEN;
                r_cnt_reg <= '0;
            end else if (r_hs) begin
                r_cnt_reg <= r_cnt_reg + 4'd1;
            end
            if (r_fetch_en) begin
                r_addr_reg <= r_fetch_addr;
                r_err_reg  <= r_fetch_oor;
            end
        end
    end

    // ---------------- storage: one byte-wide RAM per lane ----------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [7:0] mem [MEM_DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (w_en && WSTRB[gi]) begin
                    mem[w_idx] <= WDATA[8*gi +: 8];
                end
            end

            // Read-first: a same-edge write to this word is not visible here.
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    rd_byte_reg <= '0;
                end else if (r_fetch_en) begin
                    rd_byte_reg <= mem[r_fetch_idx];
                end
            end

            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    assign ARREADY = run_reg && (r_state_reg == R_IDLE);
    assign RVALID  = (r_state_reg == R_DATA);
    assign RLAST   = r_last;
    assign RID     = r_id_reg;
    assign RDATA   = r_err_reg ? '0 : rd_word;
    assign RRESP   = {2'b00, r_err_reg, r_err_reg};

    // Sideband fields that carry no meaning for this slave.
    logic unused_sideband;
    assign unused_sideband = ^{AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPROT,
                               ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPROT, WID};
    logic unused_addr_bits;
`ifdef AXI_SLAVE_DECERR_EN
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0]};
`else
    assign unused_addr_bits = ^{AWADDR[1:0], ARADDR[1:0],
                                AWADDR[ADDR_WIDTH-1:2+IDX_W], ARADDR[ADDR_WIDTH-1:2+IDX_W]};
`endif

endmodule
